axi4_lite_cpu_bridge: RTL and testbench
=======================================

# axi4_lite_cpu_bridge

Sequential adapter between the RV32IM core's memory stage and the AXI4-Lite peripheral subsystem's start/busy command port. It turns load/store requests (funct3-encoded) into aligned word transactions with byte strobes, stalls the pipeline until the bus transaction completes, and returns sign- or zero-extended load data. It also catches misaligned or illegal accesses so that no bus transaction is issued for them.

## Interface
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width (only 32 is supported).
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- mem_req_valid  in  1  core presents a load/store request.
- mem_req_write  in  1  1 = store, 0 = load.
- mem_addr  in  ADDR_WIDTH  byte address.
- mem_wdata  in  DATA_WIDTH  store data, right-justified.
- mem_funct3  in  3  RV32 width/sign code.
- stall  out  1  holds the core pipeline.
- mem_rdata  out  DATA_WIDTH  extended load result.
- mem_rdata_valid  out  1  one-cycle pulse when mem_rdata is valid.
- misaligned  out  1  one-cycle pulse when the access is faulted and not issued.
- write_start  out  1  one-cycle write command pulse.
- write_addr  out  ADDR_WIDTH  word-aligned write address.
- write_data  out  DATA_WIDTH  lane-replicated write data.
- write_strobe  out  4  byte enables.
- write_busy  in  1  write transaction in flight.
- read_start  out  1  one-cycle read command pulse.
- read_addr  out  ADDR_WIDTH  word-aligned read address.
- read_data  in  DATA_WIDTH  read word; valid in the first cycle busy is low after a read.
- read_busy  in  1  read transaction in flight.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - On mem_req_valid, latch write, addr, wdata and funct3.
  - If the access is faulted, go to DONE with a fault flag set. Otherwise go to ISSUE.
- **ISSUE**
  - Pulse write_start or read_start for exactly one cycle.
  - Hold the address, data and strobe outputs stable from ISSUE through WAIT.
  - Go to WAIT.
- **WAIT**
  - Set a seen_busy flag once the relevant busy input is 1.
  - Exit on the first cycle where seen_busy=1 and busy=0. Go to DONE.
  - For a load, capture read_data in that exit cycle.
  - The master asserts busy in the cycle after start.
- **DONE**
  - stall=0.
  - Pulse mem_rdata_valid for a completed load, or misaligned for a faulted access.
  - Go to IDLE. The core advances at this edge, so the old request is never re-captured.
- Stall rule: stall = (IDLE && mem_req_valid) || ISSUE || WAIT.
- Stores:
  - SB (000): strobe = 4'b0001 << addr[1:0]; data = {4{wdata[7:0]}}.
  - SH (001): strobe = addr[1] ? 4'b1100 : 4'b0011; data = {2{wdata[15:0]}}.
  - SW (010): strobe = 4'b1111; data = wdata.
- Loads:
  - Select the byte/half lane with addr[1:0].
  - LB (000) and LH (001) sign-extend; LBU (100) and LHU (101) zero-extend; LW (010) passes the word through.
- Bus addresses are {addr[31:2], 2'b00}.
- Faults (no bus traffic, mem_rdata=0):
  - halfword access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - load funct3 of 011, 110 or 111;
  - store funct3 above 010.
- Reset values:
  - state=IDLE;
  - mem_rdata=0, all address/data outputs 0, write_strobe=0;
  - all pulse outputs 0; stall=0.
- Reset mid-transaction: return to IDLE at once and discard the pending result. The master shares rst.

## Timing
- Aligned access with bus busy for N cycles (N≥1): stall is high for 2+N+1 cycles (IDLE, ISSUE, N busy cycles, exit cycle). Completion pulse in the following DONE cycle.
- Faulted access: stall high for 1 cycle (IDLE). misaligned pulses in the next cycle.
- Back-to-back requests: a new request can be captured no earlier than the cycle after DONE. There is one IDLE gap with stall=1.
- mem_rdata holds its value until the next load completes or a fault clears it to 0.

## Test plan
- SW addr 0x0000_0104, data 0xDEADBEEF:
  - write_addr=0x104, strobe=1111, write_start high for exactly 1 cycle;
  - stall drops the cycle after busy falls.
- SB addr 0x0000_0103, data 0x000000A5: strobe=1000, write_data=0xA5A5A5A5.
- Word 0x80FF7F01 read back at 0x100:
  - LB @0x103 → 0xFFFFFF80; LBU @0x103 → 0x00000080;
  - LH @0x100 → 0x00007F01; LHU @0x102 → 0x000080FF;
  - each with a single mem_rdata_valid pulse.
- LW @0x102 and SH @0x101: misaligned pulses once, stall lasts 1 cycle, no start pulse, mem_rdata=0.
- rst asserted during WAIT of a load: the next cycle is IDLE, stall=0, no mem_rdata_valid pulse. A fresh LW afterwards completes normally.
- Two consecutive LWs to 0x2000 (the LED base, 0x00000001 written earlier): both return 0x1, with exactly one read_start per request.

Source files
------------

// File: rtl/axi4_lite_cpu_bridge.sv
// Memory-stage bridge: turns RV32 loads/stores into aligned word
// commands on a start/busy port, stalling the core until completion.
`timescale 1ns/1ps
module axi4_lite_cpu_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req_valid,
  input  logic                  mem_req_write,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [2:0]            mem_funct3,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_rdata_valid,
  output logic                  misaligned,
  output logic                  write_start,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [3:0]            write_strobe,
  input  logic                  write_busy,
  output logic                  read_start,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  read_busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic       req_write;
  logic       fault;
  logic       seen_busy;
  logic [1:0] lane;
  logic [2:0] funct3;

  logic                  bad;
  logic [3:0]            st_strobe;
  logic [DATA_WIDTH-1:0] st_data;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [7:0]            rbyte;
  logic [15:0]           rhalf;
  logic                  busy;
  logic                  exit_wait;

  always_comb begin
    bad = 1'b0;
    if (mem_req_write)
      bad = mem_funct3[2] | (mem_funct3[1:0] == 2'b11);
    else
      bad = (mem_funct3[1:0] == 2'b11) | (mem_funct3 == 3'b110);
    if (mem_funct3[1:0] == 2'b01 && mem_addr[0])
      bad = 1'b1;
    if (mem_funct3[1:0] == 2'b10 && mem_addr[1:0] != 2'b00)
      bad = 1'b1;
  end

  // Narrow stores replicate the datum across all lanes; strobes pick one
  always_comb begin
    st_strobe = 4'b1111;
    st_data   = mem_wdata;
    unique case (1'b1)
      mem_funct3[1:0] == 2'b00: begin
        st_strobe = 4'b0001 << mem_addr[1:0];
        st_data   = {4{mem_wdata[7:0]}};
      end
      mem_funct3[1:0] == 2'b01: begin
        st_strobe = mem_addr[1] ? 4'b1100 : 4'b0011;
        st_data   = {2{mem_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rbyte   = read_data[8*lane +: 8];
    rhalf   = lane[1] ? read_data[31:16] : read_data[15:0];
    ld_data = read_data;
    unique case (1'b1)
      funct3 == 3'b000: ld_data = {{24{rbyte[7]}}, rbyte};
      funct3 == 3'b100: ld_data = {24'd0, rbyte};
      funct3 == 3'b001: ld_data = {{16{rhalf[15]}}, rhalf};
      funct3 == 3'b101: ld_data = {16'd0, rhalf};
      default: ;
    endcase
  end

  assign busy      = req_write ? write_busy : read_busy;
  assign exit_wait = (state == WAIT) && seen_busy && !busy;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (mem_req_valid)
          state_nxt = bad ? DONE : ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:
        if (exit_wait)
          state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req_write    <= 1'b0;
      fault        <= 1'b0;
      seen_busy    <= 1'b0;
      lane         <= '0;
      funct3       <= '0;
      mem_rdata    <= '0;
      write_addr   <= '0;
      write_data   <= '0;
      write_strobe <= '0;
      read_addr    <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE:
          if (mem_req_valid) begin
            req_write <= mem_req_write;
            fault     <= bad;
            seen_busy <= 1'b0;
            lane      <= mem_addr[1:0];
            funct3    <= mem_funct3;
            if (bad) begin
              mem_rdata <= '0;
            end else if (mem_req_write) begin
              write_addr   <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
              write_data   <= st_data;
              write_strobe <= st_strobe;
            end else begin
              read_addr <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
            end
          end
        WAIT: begin
          if (busy)
            seen_busy <= 1'b1;
          if (exit_wait && !req_write)
            mem_rdata <= ld_data;
        end
        default: ;
      endcase
    end
  end

  assign stall = ((state == IDLE) && mem_req_valid)
               || (state == ISSUE) || (state == WAIT);
  assign write_start     = (state == ISSUE) && req_write;
  assign read_start      = (state == ISSUE) && !req_write;
  assign mem_rdata_valid = (state == DONE) && !fault && !req_write;
  assign misaligned      = (state == DONE) && fault;

endmodule

// File: tb/tb_axi4_lite_cpu_bridge.sv
// Directed bench for axi4_lite_cpu_bridge with a behavioural
// start/busy master backed by a small word memory.
`timescale 1ns/1ps
module tb_axi4_lite_cpu_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic        stall;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;
  logic        misaligned;
  logic        write_start;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic [3:0]  write_strobe;
  logic        write_busy;
  logic        read_start;
  logic [31:0] read_addr;
  logic [31:0] read_data;
  logic        read_busy;

  int checks = 0;
  int failures = 0;
  int busy_n = 2;
  int wleft, rleft;
  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  axi4_lite_cpu_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .stall(stall),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .misaligned(misaligned), .write_start(write_start),
    .write_addr(write_addr), .write_data(write_data),
    .write_strobe(write_strobe), .write_busy(write_busy),
    .read_start(read_start), .read_addr(read_addr),
    .read_data(read_data), .read_busy(read_busy)
  );

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Master: busy rises the cycle after start and lasts busy_n cycles
  always @(posedge clk) begin
    if (rst) begin
      write_busy <= 1'b0;
      read_busy  <= 1'b0;
      wleft      <= 0;
      rleft      <= 0;
      read_data  <= '0;
    end else begin
      if (write_start) begin
        write_busy <= 1'b1;
        wleft      <= busy_n;
        mem[write_addr] = merge(mem.exists(write_addr) ?
                                mem[write_addr] : 32'd0,
                                write_data, write_strobe);
      end else if (wleft > 1) begin
        wleft <= wleft - 1;
      end else begin
        wleft      <= 0;
        write_busy <= 1'b0;
      end
      if (read_start) begin
        read_busy <= 1'b1;
        rleft     <= busy_n;
        read_data <= mem.exists(read_addr) ? mem[read_addr] : 32'd0;
      end else if (rleft > 1) begin
        rleft <= rleft - 1;
      end else begin
        rleft     <= 0;
        read_busy <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    int          busy;
    logic        flt;
    logic [31:0] rdata;
    logic [3:0]  strb;
    logic [31:0] wd;
  } vec_t;

  task automatic run(input vec_t x);
    int st, starts, rv, mis;
    logic [3:0]  s;
    logic [31:0] d, a;
    bit done;
    st = 0; starts = 0; rv = 0; mis = 0;
    s = '0; d = '0; a = '0; done = 0;
    @(negedge clk);
    busy_n        = x.busy;
    mem_req_valid = 1'b1;
    mem_req_write = x.wr;
    mem_addr      = x.addr;
    mem_wdata     = x.wdata;
    mem_funct3    = x.f3;
    for (int c = 0; c < 60 && !done; c++) begin
      #1;
      if (write_start || read_start) begin
        starts++;
        s = write_strobe;
        d = write_data;
        a = x.wr ? write_addr : read_addr;
      end
      rv  += int'(mem_rdata_valid);
      mis += int'(misaligned);
      if (stall) st++;
      else begin
        done = 1;
        mem_req_valid = 1'b0;
      end
      if (!done) @(negedge clk);
    end
    chk({x.name, "/completed"}, 32'(done), 32'd1);
    chk({x.name, "/stall_cycles"}, st, x.flt ? 1 : 3 + x.busy);
    chk({x.name, "/start_pulses"}, starts, x.flt ? 0 : 1);
    chk({x.name, "/misaligned"}, mis, x.flt ? 1 : 0);
    chk({x.name, "/rdata_valid"}, rv, (!x.wr && !x.flt) ? 1 : 0);
    if (x.flt || !x.wr)
      chk({x.name, "/mem_rdata"}, mem_rdata, x.rdata);
    if (!x.flt)
      chk({x.name, "/bus_addr"}, a, {x.addr[31:2], 2'b00});
    if (x.wr && !x.flt) begin
      chk({x.name, "/strobe"}, 32'(s), 32'(x.strb));
      chk({x.name, "/write_data"}, d, x.wd);
    end
    @(negedge clk);
    #1;
    chk({x.name, "/gap_pulses"},
        {30'd0, mem_rdata_valid, misaligned}, 32'd0);
    chk({x.name, "/gap_stall"}, 32'(stall), 32'd0);
  endtask

  vec_t v[$];

  initial begin
    v.push_back('{"sw_104", 1, 32'h104, 32'hDEADBEEF, 3'b010, 1,
                  0, 0, 4'hF, 32'hDEADBEEF});
    v.push_back('{"sb_103", 1, 32'h103, 32'h000000A5, 3'b000, 2,
                  0, 0, 4'h8, 32'hA5A5A5A5});
    v.push_back('{"sw_100", 1, 32'h100, 32'h80FF7F01, 3'b010, 3,
                  0, 0, 4'hF, 32'h80FF7F01});
    v.push_back('{"lb_103", 0, 32'h103, 0, 3'b000, 2,
                  0, 32'hFFFFFF80, 0, 0});
    v.push_back('{"lbu_103", 0, 32'h103, 0, 3'b100, 1,
                  0, 32'h00000080, 0, 0});
    v.push_back('{"lh_100", 0, 32'h100, 0, 3'b001, 2,
                  0, 32'h00007F01, 0, 0});
    v.push_back('{"lhu_102", 0, 32'h102, 0, 3'b101, 4,
                  0, 32'h000080FF, 0, 0});
    v.push_back('{"lw_102", 0, 32'h102, 0, 3'b010, 2,
                  1, 32'h0, 0, 0});
    v.push_back('{"lw_104", 0, 32'h104, 0, 3'b010, 1,
                  0, 32'hDEADBEEF, 0, 0});
    v.push_back('{"sh_101", 1, 32'h101, 32'h1234, 3'b001, 2,
                  1, 32'h0, 0, 0});
    v.push_back('{"sh_102", 1, 32'h102, 32'hFFFF1234, 3'b001, 2,
                  0, 0, 4'hC, 32'h12341234});
    v.push_back('{"ld_f3_011", 0, 32'h100, 0, 3'b011, 2,
                  1, 32'h0, 0, 0});
    v.push_back('{"st_f3_011", 1, 32'h100, 0, 3'b011, 2,
                  1, 32'h0, 0, 0});
    v.push_back('{"sw_2000", 1, 32'h2000, 32'h1, 3'b010, 2,
                  0, 0, 4'hF, 32'h1});
    v.push_back('{"lw_2000_a", 0, 32'h2000, 0, 3'b010, 2,
                  0, 32'h1, 0, 0});
    v.push_back('{"lw_2000_b", 0, 32'h2000, 0, 3'b010, 3,
                  0, 32'h1, 0, 0});

    rst = 1'b1;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    mem_funct3 = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset/stall", 32'(stall), 32'd0);
    chk("reset/mem_rdata", mem_rdata, 32'd0);
    chk("reset/write_strobe", 32'(write_strobe), 32'd0);
    chk("reset/addrs", write_addr | read_addr | write_data, 32'd0);
    chk("reset/pulses", {28'd0, write_start, read_start,
        mem_rdata_valid, misaligned}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < v.size(); i++)
      run(v[i]);

    // Reset while a load is waiting on the bus
    @(negedge clk);
    busy_n = 5;
    mem_req_valid = 1'b1;
    mem_req_write = 1'b0;
    mem_addr = 32'h100;
    mem_funct3 = 3'b010;
    begin
      bit seen;
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        #1;
        if (read_busy) seen = 1;
      end
      chk("rst_mid/busy_seen", 32'(seen), 32'd1);
    end
    chk("rst_mid/stall_in_wait", 32'(stall), 32'd1);
    rst = 1'b1;
    mem_req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid/stall", 32'(stall), 32'd0);
    chk("rst_mid/rdata_valid", 32'(mem_rdata_valid), 32'd0);
    chk("rst_mid/mem_rdata", mem_rdata, 32'd0);
    rst = 1'b0;
    begin
      int rv;
      rv = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        #1;
        rv += int'(mem_rdata_valid) + int'(stall) + int'(read_start);
      end
      chk("rst_mid/quiet_after", rv, 0);
    end
    run('{"lw_after_rst", 0, 32'h2000, 0, 3'b010, 2,
          0, 32'h1, 0, 0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
